// File: rtl/sdram_defs.sv
// Shared SDRAM controller definitions: command encodings, mode-register timing
// defaults and the read-engine state type.
package sdram_defs;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;

    localparam int DEF_CAS_LAT   = 3;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_TRCD      = 2;
    localparam int DEF_TRP       = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_TRCD_W,
        S_READ,
        S_PRE,
        S_TRP_W,
        S_DRAIN
    } rd_state_e;

    function automatic int width_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sdram_read_capture.sv
// Read data capture: tracks in-flight bursts with a valid shift register and
// registers DQ while a burst is on the bus.
module sdram_rd_capture
    import sdram_defs::*;
#(
    parameter int CAS_LAT   = DEF_CAS_LAT,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int DW        = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          issue_i,
    input  logic [DW-1:0] dq_i,
    output logic [DW-1:0] data_o,
    output logic          vld_o,
    output logic          busy_o
);

    localparam int DEPTH = CAS_LAT + BURST_LEN;

    logic [DEPTH-1:0] sh_q;
    logic [DW-1:0]    data_q;
    logic             vld_q;
    logic             dq_live;

    // Bit k set means a READ went out k+1 cycles ago; DQ carries its burst
    // while the bit sits in the CAS_LAT-1 .. CAS_LAT+BURST_LEN-2 window.
    assign dq_live = |sh_q[CAS_LAT-1 +: BURST_LEN];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q   <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            sh_q  <= {sh_q[DEPTH-2:0], issue_i};
            vld_q <= dq_live;
            if (dq_live) data_q <= dq_i;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign busy_o = |sh_q;

endmodule

// File: rtl/sdram_read.sv
// SDRAM read-path engine: reads one full row of bank 0 in BL bursts, yielding
// the command bus to refresh at burst boundaries and resuming afterwards.
module sdram_read
    import sdram_defs::*;
#(
    parameter int CAS_LAT   = DEF_CAS_LAT,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TRCD      = DEF_TRCD,
    parameter int TRP       = DEF_TRP,
    parameter int COL_NUM   = 512
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rd_trig,
    input  logic [11:0] rd_row,
    input  logic        rd_en,
    input  logic        refr_req,
    output logic        rd_req,
    output logic        rd_end,
    output logic        rd_done,
    output logic [3:0]  rd_cmd,
    output logic [11:0] rd_addr,
    input  logic [15:0] sdram_dq,
    output logic [15:0] rd_data,
    output logic        rd_data_vld
);

    localparam int CW = width_min1(COL_NUM);
    localparam int BW = width_min1(BURST_LEN);

    rd_state_e     state_q;
    logic [11:0]   row_q;
    logic [CW-1:0] col_q;
    logic          row_active_q;
    logic [BW-1:0] burst_q;
    logic [3:0]    wait_q;
    logic [3:0]    cmd_q;
    logic [11:0]   addr_q;
    logic          req_q;
    logic          end_q;
    logic          done_q;
    logic          cap_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            row_active_q <= 1'b0;
            burst_q      <= '0;
            wait_q       <= '0;
            cmd_q        <= CMD_NOP;
            addr_q       <= '0;
            req_q        <= 1'b0;
            end_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            end_q  <= 1'b0;
            done_q <= 1'b0;

            // end_q blocks a trigger landing on the final rd_end cycle
            if (rd_trig && state_q == S_IDLE && !row_active_q && !end_q) begin
                row_q        <= rd_row;
                col_q        <= '0;
                row_active_q <= 1'b1;
                req_q        <= 1'b1;
            end

            if (state_q != S_IDLE && !rd_en) begin
                state_q <= S_IDLE;
                cmd_q   <= CMD_NOP;
                addr_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Grant is still high during our own rd_end cycle
                        if (rd_en && row_active_q && !end_q) begin
                            state_q <= S_ACT;
                            cmd_q   <= CMD_ACT;
                            addr_q  <= row_q;
                        end
                    end
                    S_ACT: begin
                        state_q <= S_TRCD_W;
                        wait_q  <= '0;
                        cmd_q   <= CMD_NOP;
                        addr_q  <= '0;
                    end
                    S_TRCD_W: begin
                        if (wait_q == 4'(TRCD - 1)) begin
                            state_q <= S_READ;
                            burst_q <= '0;
                            cmd_q   <= CMD_READ;
                            addr_q  <= 12'(col_q);
                            col_q   <= col_q + CW'(BURST_LEN);
                        end else begin
                            wait_q <= wait_q + 4'd1;
                        end
                    end
                    S_READ: begin
                        cmd_q   <= CMD_NOP;
                        addr_q  <= '0;
                        burst_q <= burst_q + BW'(1);
                        if (burst_q == BW'(BURST_LEN - 1)) begin
                            // Pointer back at 0 here means the row is complete
                            if (col_q == '0 || refr_req) begin
                                state_q <= S_PRE;
                                cmd_q   <= CMD_PRE;
                            end else begin
                                burst_q <= '0;
                                cmd_q   <= CMD_READ;
                                addr_q  <= 12'(col_q);
                                col_q   <= col_q + CW'(BURST_LEN);
                            end
                        end
                    end
                    S_PRE: begin
                        state_q <= S_TRP_W;
                        wait_q  <= '0;
                        cmd_q   <= CMD_NOP;
                        addr_q  <= '0;
                    end
                    S_TRP_W: begin
                        if (wait_q == 4'(TRP - 1)) state_q <= S_DRAIN;
                        else                       wait_q  <= wait_q + 4'd1;
                    end
                    S_DRAIN: begin
                        if (!cap_busy) begin
                            state_q <= S_IDLE;
                            end_q   <= 1'b1;
                            if (col_q == '0) begin
                                done_q       <= 1'b1;
                                row_active_q <= 1'b0;
                                req_q        <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    sdram_rd_capture #(
        .CAS_LAT  (CAS_LAT),
        .BURST_LEN(BURST_LEN),
        .DW       (16)
    ) u_capture (
        .clk_i  (sys_clk),
        .rst_n_i(sys_rst_n),
        .issue_i(cmd_q == CMD_READ),
        .dq_i   (sdram_dq),
        .data_o (rd_data),
        .vld_o  (rd_data_vld),
        .busy_o (cap_busy)
    );

    assign rd_cmd  = cmd_q;
    assign rd_addr = addr_q;
    assign rd_req  = req_q;
    assign rd_end  = end_q;
    assign rd_done = done_q;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: a behavioural SDRAM answers READs with {row,col} words;
// command/data logs are checked against timing and ordering rules.
module tb_sdram_read;
    import sdram_defs::*;

    localparam int CL = 3;
    localparam int BL = 4;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [11:0] addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig [2];
    logic [11:0] row_in [2];
    logic        en [2];
    logic        refr [2];
    logic        req [2];
    logic        rend [2];
    logic        rdone [2];
    logic [3:0]  cmd [2];
    logic [11:0] addr [2];
    logic [15:0] dq [2];
    logic [15:0] data [2];
    logic        vld [2];

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    ev_t         evq [2][$];
    logic [15:0] words [2][$];
    int          vldc [2][$];
    int          endc [2][$];
    int          donec [2][$];
    logic [11:0] open_row [2];
    logic [15:0] sv [2][16];
    bit          sok [2][16];

    always #5 clk = ~clk;

    sdram_read #(.COL_NUM(16)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .rd_trig(trig[0]), .rd_row(row_in[0]),
        .rd_en(en[0]), .refr_req(refr[0]), .rd_req(req[0]), .rd_end(rend[0]),
        .rd_done(rdone[0]), .rd_cmd(cmd[0]), .rd_addr(addr[0]), .sdram_dq(dq[0]),
        .rd_data(data[0]), .rd_data_vld(vld[0])
    );

    sdram_read #(.COL_NUM(512)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .rd_trig(trig[1]), .rd_row(row_in[1]),
        .rd_en(en[1]), .refr_req(refr[1]), .rd_req(req[1]), .rd_end(rend[1]),
        .rd_done(rdone[1]), .rd_cmd(cmd[1]), .rd_addr(addr[1]), .sdram_dq(dq[1]),
        .rd_data(data[1]), .rd_data_vld(vld[1])
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SDRAM model and bus monitor: a READ seen in cycle R drives DQ in R+CL..R+CL+BL-1
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int         slot;
            logic [8:0] c;
            ev_t        e;
            if (cmd[d] != CMD_NOP) begin
                e.cyc = cyc; e.cmd = cmd[d]; e.addr = addr[d];
                evq[d].push_back(e);
            end
            if (cmd[d] == CMD_ACT) open_row[d] = addr[d];
            if (cmd[d] == CMD_READ) begin
                for (int i = 0; i < BL; i++) begin
                    slot = (cyc + CL + i) % 16;
                    c = addr[d][8:0] + 9'(i);
                    sv[d][slot] = {open_row[d][7:0], c[7:0]};
                    sok[d][slot] = 1'b1;
                end
            end
            if (vld[d]) begin
                words[d].push_back(data[d]);
                vldc[d].push_back(cyc);
            end
            if (rend[d])  endc[d].push_back(cyc);
            if (rdone[d]) donec[d].push_back(cyc);
            slot = cyc % 16;
            dq[d] = sok[d][slot] ? sv[d][slot] : 16'($urandom);
            sok[d][slot] = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    function automatic int nth_cyc(input int d, input logic [3:0] c, input int n);
        int k = 0;
        for (int i = 0; i < evq[d].size(); i++)
            if (evq[d][i].cmd == c) begin
                if (k == n) return evq[d][i].cyc;
                k++;
            end
        return -1;
    endfunction

    function automatic int nth_addr(input int d, input logic [3:0] c, input int n);
        int k = 0;
        for (int i = 0; i < evq[d].size(); i++)
            if (evq[d][i].cmd == c) begin
                if (k == n) return int'(evq[d][i].addr);
                k++;
            end
        return -1;
    endfunction

    function automatic int count_cmd(input int d, input logic [3:0] c);
        int k = 0;
        for (int i = 0; i < evq[d].size(); i++) if (evq[d][i].cmd == c) k++;
        return k;
    endfunction

    // Word i of a row must be {row[7:0], i[7:0]}
    function automatic int word_errs(input int d, input logic [11:0] r);
        int e = 0;
        logic [7:0] ci;
        for (int i = 0; i < words[d].size(); i++) begin
            ci = 8'(i);
            if (words[d][i] !== {r[7:0], ci}) e++;
        end
        return e;
    endfunction

    // The i-th READ of a row addresses column BL*i, across any refresh yields
    function automatic int col_errs(input int d);
        int e = 0;
        for (int i = 0; i < count_cmd(d, CMD_READ); i++)
            if (nth_addr(d, CMD_READ, i) != BL * i) e++;
        return e;
    endfunction

    function automatic int act_errs(input int d, input logic [11:0] r);
        int e = 0;
        for (int i = 0; i < count_cmd(d, CMD_ACT); i++)
            if (nth_addr(d, CMD_ACT, i) != int'(r)) e++;
        return e;
    endfunction

    task automatic clr(input int d);
        evq[d].delete(); words[d].delete(); vldc[d].delete();
        endc[d].delete(); donec[d].delete();
    endtask

    task automatic pulse(input int d, input logic [11:0] r);
        @(negedge clk);
        row_in[d] = r;
        trig[d] = 1'b1;
        @(negedge clk);
        trig[d] = 1'b0;
    endtask

    // Arbiter stand-in: grant until rd_end, drop grant the cycle after.
    // rk>0 raises refr_req once the rk-th READ has been seen.
    task automatic run_grant(input int d, input int rk);
        int reads = 0;
        bit got = 1'b0;
        en[d] = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (cmd[d] == CMD_READ) reads++;
            if (rk != 0 && reads >= rk) refr[d] = 1'b1;
            if (rend[d]) got = 1'b1;
        end
        chk("grant_end_seen", got, 1);
        @(negedge clk);
        en[d] = 1'b0;
        refr[d] = 1'b0;
    endtask

    initial begin
        int t, t2, n0, rk, g, exp_ends;
        logic [11:0] r;
        bit got;
        for (int d = 0; d < 2; d++) begin
            trig[d] = 1'b0; row_in[d] = '0; en[d] = 1'b0; refr[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_cmd", cmd[0], CMD_NOP);
        chk("rst_addr", addr[0], 0);
        chk("rst_req", req[0], 0);
        chk("rst_end", rend[0], 0);
        chk("rst_done", rdone[0], 0);
        chk("rst_vld", vld[0], 0);
        chk("rst_data", data[0], 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic row read, with the grant held off for a while first
        clr(0);
        pulse(0, 12'h05A);
        chk("req_after_trig", req[0], 1);
        repeat (5) @(negedge clk);
        chk("no_grant_req", req[0], 1);
        chk("no_grant_nocmd", evq[0].size(), 0);
        run_grant(0, 0);
        t = nth_cyc(0, CMD_ACT, 0);
        chk("act_addr", nth_addr(0, CMD_ACT, 0), 12'h05A);
        for (int i = 0; i < 4; i++) begin
            chk("read_cycle", nth_cyc(0, CMD_READ, i), t + 3 + 4 * i);
            chk("read_col", nth_addr(0, CMD_READ, i), 4 * i);
        end
        chk("pre_cycle", nth_cyc(0, CMD_PRE, 0), t + 19);
        chk("n_vld", vldc[0].size(), 16);
        chk("vld_first", qget(vldc[0], 0), t + 7);
        chk("vld_last", qget(vldc[0], 15), t + 22);
        chk("word_errs", word_errs(0, 12'h05A), 0);
        chk("n_end", endc[0].size(), 1);
        chk("n_done", donec[0].size(), 1);
        chk("done_with_end", qget(donec[0], 0), qget(endc[0], 0));
        chk("end_after_data", qget(endc[0], 0) > t + 22, 1);
        chk("req_low_after", req[0], 0);

        // Refresh yield after the second burst, ignored trigger, then resume
        clr(0);
        pulse(0, 12'h05A);
        run_grant(0, 2);
        t = nth_cyc(0, CMD_ACT, 0);
        chk("y_n_read", count_cmd(0, CMD_READ), 2);
        chk("y_pre_cycle", nth_cyc(0, CMD_PRE, 0), t + 11);
        chk("y_n_end", endc[0].size(), 1);
        chk("y_no_done", donec[0].size(), 0);
        chk("y_req_held", req[0], 1);
        n0 = evq[0].size();
        pulse(0, 12'h100);
        repeat (6) @(negedge clk);
        chk("ign_trig_nocmd", evq[0].size(), n0);
        chk("ign_trig_req", req[0], 1);
        run_grant(0, 0);
        t2 = nth_cyc(0, CMD_ACT, 1);
        chk("r_act_addr", nth_addr(0, CMD_ACT, 1), 12'h05A);
        chk("r_read_col", nth_addr(0, CMD_READ, 2), 8);
        chk("r_read_cycle", nth_cyc(0, CMD_READ, 2), t2 + 3);
        chk("r_n_words", words[0].size(), 16);
        chk("r_word_errs", word_errs(0, 12'h05A), 0);
        chk("r_n_done", donec[0].size(), 1);
        chk("r_req_low", req[0], 0);

        // Random rows, refresh points and grant gaps
        for (int it = 0; it < 4; it++) begin
            r = 12'($urandom);
            rk = $urandom_range(0, 5);
            exp_ends = (rk >= 1 && rk <= 3) ? 2 : 1;
            g = 0;
            clr(0);
            pulse(0, r);
            while (donec[0].size() == 0 && g < 4) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                run_grant(0, (g == 0) ? rk : 0);
                g++;
            end
            chk("rnd_n_words", words[0].size(), 16);
            chk("rnd_word_errs", word_errs(0, r), 0);
            chk("rnd_col_errs", col_errs(0), 0);
            chk("rnd_act_errs", act_errs(0, r), 0);
            chk("rnd_n_done", donec[0].size(), 1);
            chk("rnd_n_end", endc[0].size(), exp_ends);
            chk("rnd_req_low", req[0], 0);
        end

        // Reset in the middle of a row
        clr(0);
        pulse(0, 12'h033);
        en[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (vld[0]) got = 1'b1;
        end
        chk("mr_data_seen", got, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_cmd_nop", cmd[0], CMD_NOP);
        chk("mr_req_low", req[0], 0);
        chk("mr_vld_low", vld[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr(0);
        repeat (30) @(negedge clk);
        chk("mr_no_cmd", evq[0].size(), 0);
        chk("mr_no_vld", vldc[0].size(), 0);
        chk("mr_no_end", endc[0].size() + donec[0].size(), 0);
        chk("mr_req_after", req[0], 0);
        en[0] = 1'b0;

        // Full 512-column row: wrap boundary
        clr(1);
        pulse(1, 12'h0A5);
        run_grant(1, 0);
        chk("w_n_read", count_cmd(1, CMD_READ), 128);
        chk("w_last_col", nth_addr(1, CMD_READ, 127), 508);
        chk("w_pre_cycle", nth_cyc(1, CMD_PRE, 0), nth_cyc(1, CMD_READ, 127) + 4);
        chk("w_col_errs", col_errs(1), 0);
        chk("w_n_words", words[1].size(), 512);
        chk("w_word_errs", word_errs(1, 12'h0A5), 0);
        chk("w_n_done", donec[1].size(), 1);
        chk("w_req_low", req[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_read.md
Name: sdram_read

Overview:
- Read-path engine of the SDRAM controller; the arbiter enters READ and hands the command bus to this block.
- Same handshake style as the auto-refresh block: request out, enable in, end pulse out.
- On a trigger it reads one full row of bank 0 in BL=4 bursts and streams words out with a valid strobe.
- If refresh is pending at a burst boundary, it yields the bus (precharge + rd_end), then resumes at the next column.

Parameters:
- CAS_LAT, 3, CAS latency programmed by init; READ at cycle R puts data on DQ in cycles R+CAS_LAT .. R+CAS_LAT+BURST_LEN-1.
- BURST_LEN, 4, burst length programmed by init; one READ per BURST_LEN cycles.
- TRCD, 2, NOP cycles between ACT and first READ.
- TRP, 2, NOP cycles after PRE.
- COL_NUM, 512, columns per row; must be a multiple of BURST_LEN.

Ports:
- sys_clk  in  1  controller clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- rd_trig  in  1  one-cycle start pulse; ignored while a row is in progress.
- rd_row  in  12  row address, sampled with rd_trig.
- rd_en  in  1  arbiter grant, level; held high until the cycle after rd_end.
- refr_req  in  1  refresh pending from the refresh block.
- rd_req  out  1  request to arbiter.
- rd_end  out  1  one-cycle pulse: bus released.
- rd_done  out  1  one-cycle pulse: whole row delivered.
- rd_cmd  out  4  {cs_n,ras_n,cas_n,we_n}. NOP=0111, ACT=0011, READ=0101, PRE=0010.
- rd_addr  out  12  SDRAM address bus.
- sdram_dq  in  16  DQ input, sampled on sys_clk.
- rd_data  out  16  registered read word.
- rd_data_vld  out  1  rd_data valid.

Behaviour:
- Reset values: state IDLE; rd_req, rd_end, rd_done, rd_data_vld = 0; rd_cmd = NOP; rd_addr, rd_data, row and column registers = 0.
- rd_trig in IDLE with no row active:
  - latch rd_row; column pointer = 0; row_active = 1; rd_req = 1.
- rd_req stays high until the final rd_end of the row. It stays high across refresh yields.
- States: IDLE, ACT, TRCD_W, READ, PRE, TRP_W, DRAIN.
  - IDLE -> ACT when rd_en=1 and row_active=1.
  - ACT, one cycle: rd_cmd=ACT, rd_addr=row.
  - TRCD_W: NOP for TRCD cycles.
  - READ: burst counter 0..BURST_LEN-1.
    - At count 0: rd_cmd=READ, rd_addr={3'b000 (A10=0, no auto-precharge), column}.
    - Other counts: NOP.
    - Column pointer += BURST_LEN at count 0.
    - At count BURST_LEN-1: go to PRE if the column pointer has wrapped to 0 (row finished) or refr_req=1; otherwise restart the burst.
  - PRE, one cycle: rd_cmd=PRE, rd_addr=0 (single bank).
  - TRP_W: NOP for TRP cycles.
  - DRAIN: wait until the data pipeline is empty, then go to IDLE. In that cycle rd_end=1.
    - If the row is finished, also rd_done=1, row_active=0, rd_req=0.
- Back-to-back bursts are gapless: READ commands every BURST_LEN cycles.
- Data path:
  - A (CAS_LAT+BURST_LEN)-deep valid shift register is loaded at each READ issue.
  - sdram_dq is registered into rd_data.
  - rd_data_vld is high in cycles R+CAS_LAT+1 .. R+CAS_LAT+BURST_LEN.
  - rd_data_vld is independent of state: words from the final burst still emerge while in PRE, TRP_W and DRAIN.
- Resume after refresh:
  - The next rd_en grant re-issues ACT for the same row.
  - Reading continues at the saved column; no word is duplicated or skipped.
- refr_req mid-burst: no effect until the burst boundary.
- rd_en low while rd_req high: stay or return to IDLE, issuing only NOP.
- rd_trig while row_active: ignored, no state change.
- rd_trig coincident with the final rd_end: ignored.
- Reset mid-operation: everything returns to reset values immediately; the partial row is abandoned.
- Column width: log2(COL_NUM) bits, zero-extended onto rd_addr.

Decomposition:
- Shared package sdram_defs holds:
  - command encodings NOP, PRE, AREF, ACT, READ, WRITE;
  - CAS_LAT, BURST_LEN, TRCD, TRP defaults (the same constants init and write use).
- Natural sub-module: sdram_rd_capture, holding the valid shift register and the DQ input register.
- Top-level arbiter READ state muxes rd_cmd/rd_addr exactly as it does for refresh.

Test Plan:
- Basic row read (COL_NUM=16): rd_trig, rd_row=12'h05A, rd_en granted; ACT first seen at cycle T.
  - rd_addr=0x05A at T.
  - READs at T+3, T+7, T+11, T+15 with columns 0, 4, 8, 12.
  - PRE at T+19.
  - 16 rd_data_vld cycles, first at T+7.
  - rd_end and rd_done together, after the last word.
- Data integrity: DQ model returns {row[7:0],col[7:0]} -> rd_data sequence 0x5A00 .. 0x5A0F, in order, no gaps.
- Refresh yield: refr_req asserted during the second burst.
  - PRE after the second burst; rd_end without rd_done; rd_req stays 1.
  - Re-grant -> ACT 0x05A, first READ column 8.
  - Total 16 unique words.
- Ignored trigger: rd_trig with rd_row=0x100 during an active row -> no effect; ACT addresses remain 0x05A.
- Reset mid-READ: sys_rst_n low -> same cycle rd_cmd=NOP, rd_req=0, rd_data_vld=0; no stray output after release.
- Wrap boundary (COL_NUM=512): the last READ uses column 508, then PRE and rd_done.
